instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the instruction-memory word count.
REQ-002 Parameter AW, default 6, SHALL set the address width (2^AW = DEPTH).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 clkreset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  in  1  SHALL request a new load session.
REQ-006 finish  in  1  SHALL request an early end of the session.
REQ-007 in_valid  in  1  SHALL mark the instruction fields as valid.
REQ-008 in_ready  out  1  SHALL indicate the loader accepts a field set.
REQ-009 in_type  in  1  SHALL give the instruction type (0 = R/I form, 1 = long-immediate form).
REQ-010 in_rs, in_rd, in_rt  in  6 each  SHALL give the register fields.
REQ-011 in_funct  in  4  SHALL give the function field.
REQ-012 in_imm  in  9 and in_imm2  in  15  SHALL give the type-0 and type-1 immediates.
REQ-013 done  out  1  SHALL indicate that the session is complete.
REQ-014 load_count  out  AW+1  SHALL give the number of words written in the current session.
REQ-015 rd_addr  in  AW  SHALL be the fetch-side read address.
REQ-016 rd_data  out  32  SHALL be the fetch-side registered read data.

Function
REQ-017 States SHALL be IDLE, LOAD and DONE.
REQ-018 IDLE: in_ready=0, done=0; start=1 -> LOAD, with wr_ptr and load_count cleared to 0.
REQ-019 LOAD: in_ready=1; in_valid&in_ready SHALL write the encoded word to mem[wr_ptr], then increment wr_ptr and load_count.
REQ-020 Type-0 encoding SHALL be {in_imm[8:0], in_rt, in_funct, in_rd, in_rs, 1'b0} (bits 31:23, 22:17, 16:13, 12:7, 6:1, 0).
REQ-021 Type-1 encoding SHALL be {in_imm2[14:0], in_funct, in_rd, in_rs, 1'b1}; in_rt and in_imm are ignored.
REQ-022 The write that brings load_count to DEPTH SHALL move LOAD -> DONE in the same edge; wr_ptr wraps to 0 with no further writes.
REQ-023 finish=1 in LOAD SHALL move to DONE; a simultaneous handshake SHALL still be written and counted.
REQ-024 start=1 in LOAD SHALL restart the session: wr_ptr and load_count go to 0, and any simultaneous handshake is dropped (no write).
REQ-025 start has priority over finish when both are asserted in LOAD.
REQ-026 DONE: in_ready=0, done=1, load_count holds; start=1 -> LOAD with counters cleared; finish is ignored.
REQ-027 in_valid while in_ready=0 SHALL have no effect, and fields SHALL NOT be captured.
REQ-028 rd_data SHALL update every cycle to mem[rd_addr], giving 1-cycle read latency in every state.
REQ-029 A read and a write to the same address in the same cycle SHALL return the old contents.
REQ-030 in_ready and done SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-031 clkreset=0 SHALL immediately force state=IDLE, wr_ptr=0, load_count=0, done=0, in_ready=0, rd_data=0.
REQ-032 Memory contents SHALL NOT be reset; reset in mid-LOAD SHALL abandon the session, and words already written SHALL persist.
REQ-033 After clkreset deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-034 Reset, start, one type-0 word (rs=1, rd=2, funct=3, rt=4, imm=5), then rd_addr=0 -> rd_data=0x02886102 one cycle later, load_count=1.
REQ-035 Start, one type-1 word (rs=63, rd=0, funct=15, imm2=0x7FFF), finish -> mem[0]=0xFFFFE07F, done=1, in_ready=0, load_count=1.
REQ-036 Start, 64 back-to-back handshakes with word i carrying imm=i -> DONE after the 64th edge, load_count=64, a 65th in_valid is not written, and mem[63] holds imm=63.
REQ-037 Start, 3 writes, then start and in_valid together -> load_count=0, the 4th word is not written, and the next write lands at address 0.
REQ-038 finish and in_valid together on the 5th word -> load_count=5, done=1, and mem[4] is written.
REQ-039 clkreset pulsed low mid-session after 10 writes -> outputs reset asynchronously, mem[0..9] still readable, and the next start begins at address 0.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction loader: packs R/I or long-immediate field sets into a DEPTH-word memory.
// Fetch side reads with one-cycle registered latency; memory contents survive reset.
module instr_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          clkreset,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_type,
  input  logic [5:0]    in_rs,
  input  logic [5:0]    in_rd,
  input  logic [5:0]    in_rt,
  input  logic [3:0]    in_funct,
  input  logic [8:0]    in_imm,
  input  logic [14:0]   in_imm2,
  output logic          done,
  output logic [AW:0]   load_count,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [31:0]     rd_data_q;
  logic [31:0]     wr_word;
  logic            wr_en;
  logic [31:0]     mem [DEPTH];

  // A restart in LOAD drops any handshake presented in the same cycle.
  assign wr_en = (state_q == S_LOAD) && in_valid && !start;

  always_comb begin
    if (in_type) wr_word = {in_imm2, in_funct, in_rd, in_rs, 1'b1};
    else         wr_word = {in_imm, in_rt, in_funct, in_rd, in_rs, 1'b0};
  end

  always_ff @(posedge clk or negedge clkreset) begin
    if (!clkreset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (start)                          state_d = S_LOAD;
        else if (finish)                    state_d = S_DONE;
        else if (wr_en && cnt_q == LAST_CNT) state_d = S_DONE;
      end
      S_DONE: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_LOAD:  in_ready = 1'b1;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (start) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d    = cnt_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge clkreset) begin
    if (!clkreset) begin
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= mem[rd_addr];
    end
  end

  // No reset on the array so loaded code survives an abandoned session.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  assign load_count = cnt_q;
  assign rd_data    = rd_data_q;

endmodule
